// File: rtl/carbonz380_mem_arb.sv
// carbonz380_mem_arb: two-master, single-slave memory arbiter.
// m0 (CPU) and m1 (DMA/debug loader) share one slave port. Only one
// transaction is outstanding at a time. Grants are round-robin. A response
// timeout returns an error to the requesting master.
// A late response after a WAIT timeout is swallowed via stale_q.
// Optional: define CARBON_MEM_ARB_STATS_EN for saturating grant/timeout counters.
module carbonz380_mem_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256,
  parameter int TW      = $clog2(TIMEOUT+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic            m0_req_write,
  input  logic [AW-1:0]   m0_req_addr,
  input  logic [DW-1:0]   m0_req_wdata,
  input  logic [DW/8-1:0] m0_req_wstrb,
  output logic            m0_rsp_valid,
  output logic [DW-1:0]   m0_rsp_rdata,
  output logic            m0_rsp_err,
  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic            m1_req_write,
  input  logic [AW-1:0]   m1_req_addr,
  input  logic [DW-1:0]   m1_req_wdata,
  input  logic [DW/8-1:0] m1_req_wstrb,
  output logic            m1_rsp_valid,
  output logic [DW-1:0]   m1_rsp_rdata,
  output logic            m1_rsp_err,
  output logic            s_req_valid,
  input  logic            s_req_ready,
  output logic            s_req_write,
  output logic [AW-1:0]   s_req_addr,
  output logic [DW-1:0]   s_req_wdata,
  output logic [DW/8-1:0] s_req_wstrb,
  input  logic            s_rsp_valid,
  input  logic [DW-1:0]   s_rsp_rdata,
  input  logic            s_rsp_err,
  output logic            busy,
`ifdef CARBON_MEM_ARB_STATS_EN
  output logic [31:0]     stat_grants0,
  output logic [31:0]     stat_grants1,
  output logic [31:0]     stat_timeouts,
`endif
  output logic            grant
);

  localparam int SW = DW/8;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t                 state;
  logic                   last_grant;
  logic                   stale_q;
  logic                   grant_q;
  logic [TW-1:0]          timer;
  logic                   wr_q;
  logic [AW-1:0]          addr_q;
  logic [DW-1:0]          wdata_q;
  logic [SW-1:0]          wstrb_q;
  logic [1:0]             rsp_valid_q;
  logic [1:0][DW-1:0]     rsp_rdata_q;
  logic [1:0]             rsp_err_q;

  logic [1:0]             req_valid;
  logic                   sel;
  logic                   can_grant;
  logic                   acc;
  logic                   t_exp;
  logic                   to_fire;

  assign req_valid = {m1_req_valid, m0_req_valid};

  // round-robin select: on a tie the master that did not go last wins
  always_comb begin
    sel = 1'b0;
    if (&req_valid)       sel = ~last_grant;
    else if (req_valid[1]) sel = 1'b1;
  end

  assign can_grant    = (state == IDLE) && !stale_q;
  assign acc          = can_grant && (|req_valid);
  assign m0_req_ready = can_grant && !sel && m0_req_valid;
  assign m1_req_ready = can_grant &&  sel && m1_req_valid;

  assign t_exp   = (timer == TW'(TIMEOUT-1));
  // timeout only when no completing response arrives in the same cycle
  assign to_fire = t_exp && ((state == ISSUE) || (state == WAIT && !s_rsp_valid));

  assign s_req_valid = (state == ISSUE);
  assign s_req_write = wr_q;
  assign s_req_addr  = addr_q;
  assign s_req_wdata = wdata_q;
  assign s_req_wstrb = wstrb_q;

  assign busy  = (state != IDLE) || stale_q;
  assign grant = grant_q;

  assign m0_rsp_valid = rsp_valid_q[0];
  assign m0_rsp_rdata = rsp_rdata_q[0];
  assign m0_rsp_err   = rsp_err_q[0];
  assign m1_rsp_valid = rsp_valid_q[1];
  assign m1_rsp_rdata = rsp_rdata_q[1];
  assign m1_rsp_err   = rsp_err_q[1];

  // arbiter FSM: grant, issue to slave, wait for response or timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      stale_q     <= 1'b0;
      grant_q     <= 1'b0;
      timer       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
    end else begin
      // response outputs are single-cycle pulses
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
      case (state)
        IDLE: begin
          if (stale_q) begin
            // swallow the late response, or give up waiting for it
            if (s_rsp_valid || t_exp) begin
              stale_q <= 1'b0;
              timer   <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end else if (acc) begin
            wr_q       <= sel ? m1_req_write : m0_req_write;
            addr_q     <= sel ? m1_req_addr  : m0_req_addr;
            wdata_q    <= sel ? m1_req_wdata : m0_req_wdata;
            wstrb_q    <= sel ? m1_req_wstrb : m0_req_wstrb;
            grant_q    <= sel;
            last_grant <= sel;
            timer      <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= timer + TW'(1);
          if (s_req_ready) state <= WAIT;
          if (t_exp) begin
            rsp_valid_q[grant_q] <= 1'b1;
            rsp_err_q[grant_q]   <= 1'b1;
            state                <= IDLE;
            timer                <= '0;
            // slave took the request on the final cycle: a response is coming
            if (s_req_ready) stale_q <= 1'b1;
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (s_rsp_valid) begin
            rsp_valid_q[grant_q] <= 1'b1;
            rsp_err_q[grant_q]   <= s_rsp_err;
            rsp_rdata_q[grant_q] <= (s_rsp_err || wr_q) ? '0 : s_rsp_rdata;
            state                <= IDLE;
          end else if (t_exp) begin
            rsp_valid_q[grant_q] <= 1'b1;
            rsp_err_q[grant_q]   <= 1'b1;
            stale_q              <= 1'b1;
            timer                <= '0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CARBON_MEM_ARB_STATS_EN
  // saturating accept and timeout counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants0  <= '0;
      stat_grants1  <= '0;
      stat_timeouts <= '0;
    end else begin
      if (acc && !sel && stat_grants0 != '1)  stat_grants0  <= stat_grants0 + 32'd1;
      if (acc &&  sel && stat_grants1 != '1)  stat_grants1  <= stat_grants1 + 32'd1;
      if (to_fire && stat_timeouts != '1)     stat_timeouts <= stat_timeouts + 32'd1;
    end
  end
`else
  logic unused_to;
  assign unused_to = to_fire;
`endif

endmodule
